// File: rtl/csu_dac_controller.sv
// Digital front end for the current-steering DAC current source unit:
// power sequencing, testbus select, and code segmentation with cell redundancy.
module csu_dac_controller #(
    parameter int SETTLE_CYCLES = 64,
    parameter int DRAIN_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        supply_ok,
    input  logic [1:0]  atb_sel,
    input  logic        bad_cell_en,
    input  logic [4:0]  bad_cell_idx,
    input  logic        lsb_red_en,
    input  logic [10:0] code,
    input  logic        code_valid,
    output logic        code_ready,
    output logic        pdb,
    output logic [1:0]  atb_ena,
    output logic [16:0] therm_sel,
    output logic [5:0]  bin_sel,
    output logic        bin0_red_sel,
    output logic        active,
    output logic        fault,
    output logic        sat
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {S_OFF, S_PWRUP, S_ACTIVE, S_DRAIN, S_FAULT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bad_en_q, bad_en_d;
    logic [4:0]    idx_q, idx_d;
    logic          lsb_red_q, lsb_red_d;
    logic [16:0]   therm_q, therm_d;
    logic [5:0]    bin_q, bin_d;
    logic          red_q, red_d;
    logic          sat_q, sat_d;
    logic [1:0]    atb_q, atb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            bad_en_q  <= 1'b0;
            idx_q     <= '0;
            lsb_red_q <= 1'b0;
            therm_q   <= '0;
            bin_q     <= '0;
            red_q     <= 1'b0;
            sat_q     <= 1'b0;
            atb_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bad_en_q  <= bad_en_d;
            idx_q     <= idx_d;
            lsb_red_q <= lsb_red_d;
            therm_q   <= therm_d;
            bin_q     <= bin_d;
            red_q     <= red_d;
            sat_q     <= sat_d;
            atb_q     <= atb_d;
        end
    end

    // Next state; the counter restarts from zero on every state entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bad_en_d  = bad_en_q;
        idx_d     = idx_q;
        lsb_red_d = lsb_red_q;
        case (state_q)
            S_OFF: begin
                if (en && supply_ok) begin
                    state_d   = S_PWRUP;
                    bad_en_d  = bad_cell_en;
                    idx_d     = bad_cell_idx;
                    lsb_red_d = lsb_red_en;
                end
            end
            S_PWRUP: begin
                if (!supply_ok)                state_d = S_FAULT;
                else if (!en)                  state_d = S_OFF;
                else if (cnt_q == SETTLE_LAST) state_d = S_ACTIVE;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            S_ACTIVE: begin
                if (!supply_ok) state_d = S_FAULT;
                else if (!en)   state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!supply_ok)               state_d = S_FAULT;
                else if (cnt_q == DRAIN_LAST) state_d = S_OFF;
                else                          cnt_d   = cnt_q + 1'b1;
            end
            S_FAULT: begin
                if (!en) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    always_comb begin
        pdb        = (state_q == S_PWRUP) || (state_q == S_ACTIVE) || (state_q == S_DRAIN);
        code_ready = (state_q == S_ACTIVE);
        active     = (state_q == S_ACTIVE);
        fault      = (state_q == S_FAULT);
    end

    // Segmentation of the incoming code and select register update.
    logic [10:0] code_s;
    logic [4:0]  therm_cnt;
    logic [16:0] therm_new;
    logic [5:0]  bin_new;
    logic        red_new;
    logic        xfer;

    always_comb begin
        code_s    = (code > 11'd1024) ? 11'd1024 : code;
        therm_cnt = code_s[10:6];
        therm_new = '0;
        for (int k = 0; k < 16; k++) therm_new[k] = (5'(k) < therm_cnt);
        if (bad_en_q && !idx_q[4]) begin
            therm_new[16]         = therm_new[idx_q[3:0]];
            therm_new[idx_q[3:0]] = 1'b0;
        end
        bin_new = code_s[5:0];
        red_new = 1'b0;
        if (lsb_red_q) begin
            red_new    = code_s[0];
            bin_new[0] = 1'b0;
        end
        xfer = code_valid && code_ready;

        therm_d = therm_q;
        bin_d   = bin_q;
        red_d   = red_q;
        sat_d   = sat_q;
        if (state_d != S_ACTIVE) begin
            therm_d = '0;
            bin_d   = '0;
            red_d   = 1'b0;
            sat_d   = 1'b0;
        end else if (xfer) begin
            therm_d = therm_new;
            bin_d   = bin_new;
            red_d   = red_new;
            sat_d   = (code > 11'd1024);
        end

        atb_d = (state_d == S_PWRUP || state_d == S_ACTIVE || state_d == S_DRAIN) ? atb_sel : 2'b00;
    end

    assign therm_sel    = therm_q;
    assign bin_sel      = bin_q;
    assign bin0_red_sel = red_q;
    assign sat          = sat_q;
    assign atb_ena      = atb_q;

endmodule

// File: tb/tb_csu_dac_controller.sv
// Bench for csu_dac_controller: vector table through a scoreboard queue,
// plus hand sequences for power-up, drain, fault and mid-run reset.
module tb_csu_dac_controller;

    logic        clk = 1'b0;
    logic        rst, en, supply_ok, bad_cell_en, lsb_red_en, code_valid;
    logic [1:0]  atb_sel;
    logic [4:0]  bad_cell_idx;
    logic [10:0] code;
    logic        code_ready, pdb, bin0_red_sel, active, fault, sat;
    logic [1:0]  atb_ena;
    logic [16:0] therm_sel;
    logic [5:0]  bin_sel;

    csu_dac_controller #(.SETTLE_CYCLES(64), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .supply_ok(supply_ok), .atb_sel(atb_sel),
        .bad_cell_en(bad_cell_en), .bad_cell_idx(bad_cell_idx), .lsb_red_en(lsb_red_en),
        .code(code), .code_valid(code_valid), .code_ready(code_ready), .pdb(pdb),
        .atb_ena(atb_ena), .therm_sel(therm_sel), .bin_sel(bin_sel),
        .bin0_red_sel(bin0_red_sel), .active(active), .fault(fault), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [16:0] therm;
        logic [5:0]  bin;
        logic        red;
        logic        sat;
    } exp_t;

    typedef struct packed {
        logic [10:0] code;
        logic        bad_en;
        logic [4:0]  idx;
        logic        lsb;
        exp_t        exp;
    } vec_t;

    vec_t vecs[15];
    exp_t sb[$];
    exp_t last_exp, e;
    int   nvec = 0;
    int   nmis = 0;
    logic [6:0] cur_cfg;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [10:0] c, input logic be, input logic [4:0] ix, input logic lr);
        exp_t r;
        int   cc, t;
        cc = (c > 11'd1024) ? 1024 : int'(c);
        t  = cc / 64;
        r.therm = 17'((1 << t) - 1);
        r.bin   = 6'(cc % 64);
        r.red   = 1'b0;
        r.sat   = (c > 11'd1024);
        if (be && ix < 5'd16) begin
            r.therm[16] = r.therm[ix];
            r.therm[ix] = 1'b0;
        end
        if (lr) begin
            r.red    = r.bin[0];
            r.bin[0] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] act_sel();
        exp_t a;
        a = '{therm_sel, bin_sel, bin0_red_sel, sat};
        return 32'(a);
    endfunction

    // Power down (bounded), load a remap config in OFF, power up and wait for ready.
    task automatic cfg_power(input logic b, input logic [4:0] ix, input logic l);
        int n;
        en = 1'b0;
        code_valid = 1'b0;
        step();
        n = 0;
        while ((pdb || fault) && n < 20) begin step(); n++; end
        chk("pwrdn_pdb", 32'(pdb), 32'd0);
        bad_cell_en = b; bad_cell_idx = ix; lsb_red_en = l;
        en = 1'b1;
        step();
        n = 0;
        while (!code_ready && n < 100) begin step(); n++; end
        chk("pwrup_ready", 32'(code_ready), 32'd1);
        cur_cfg = {b, ix, l};
    endtask

    initial begin
        vecs[0]  = '{11'd677,  1'b0, 5'd0,  1'b0, '{17'h003FF, 6'h25, 1'b0, 1'b0}};
        vecs[1]  = '{11'd1024, 1'b0, 5'd0,  1'b0, '{17'h0FFFF, 6'h00, 1'b0, 1'b0}};
        vecs[2]  = '{11'd2000, 1'b0, 5'd0,  1'b0, '{17'h0FFFF, 6'h00, 1'b0, 1'b1}};
        vecs[3]  = '{11'd0,    1'b0, 5'd0,  1'b0, '{17'h00000, 6'h00, 1'b0, 1'b0}};
        vecs[4]  = '{11'd63,   1'b0, 5'd0,  1'b0, '{17'h00000, 6'h3F, 1'b0, 1'b0}};
        vecs[5]  = '{11'd64,   1'b0, 5'd0,  1'b0, '{17'h00001, 6'h00, 1'b0, 1'b0}};
        vecs[6]  = '{11'd1023, 1'b0, 5'd0,  1'b0, '{17'h07FFF, 6'h3F, 1'b0, 1'b0}};
        vecs[7]  = '{11'd261,  1'b1, 5'd3,  1'b1, '{17'h10007, 6'h04, 1'b1, 1'b0}};
        vecs[8]  = '{11'd1024, 1'b1, 5'd3,  1'b1, '{17'h1FFF7, 6'h00, 1'b0, 1'b0}};
        vecs[9]  = '{11'd2047, 1'b1, 5'd3,  1'b1, '{17'h1FFF7, 6'h00, 1'b0, 1'b1}};
        vecs[10] = '{11'd100,  1'b1, 5'd3,  1'b1, '{17'h00001, 6'h24, 1'b0, 1'b0}};
        vecs[11] = '{11'd261,  1'b1, 5'd20, 1'b0, '{17'h0000F, 6'h05, 1'b0, 1'b0}};
        vecs[12] = '{11'd960,  1'b1, 5'd15, 1'b0, '{17'h07FFF, 6'h00, 1'b0, 1'b0}};
        vecs[13] = '{11'd1000, 1'b1, 5'd15, 1'b0, '{17'h07FFF, 6'h28, 1'b0, 1'b0}};
        vecs[14] = '{11'd1024, 1'b1, 5'd15, 1'b0, '{17'h17FFF, 6'h00, 1'b0, 1'b0}};

        rst = 1'b1; en = 1'b1; supply_ok = 1'b1; atb_sel = 2'b00;
        bad_cell_en = 1'b0; bad_cell_idx = '0; lsb_red_en = 1'b0;
        code = '0; code_valid = 1'b0;
        step(); step();
        chk("reset_outs", {code_ready, pdb, atb_ena, active, fault, act_sel()[24:0]}, 32'd0);

        // Power-up timing from reset release with en held high.
        rst = 1'b0;
        step();
        chk("pwrup_pdb_c1", 32'(pdb), 32'd1);
        chk("pwrup_rdy_c1", 32'(code_ready), 32'd0);
        for (int i = 2; i <= 64; i++) step();
        chk("pwrup_rdy_c64", 32'(code_ready), 32'd0);
        step();
        chk("pwrup_rdy_c65", 32'(code_ready), 32'd1);
        chk("pwrup_active", 32'(active), 32'd1);
        cur_cfg = 7'd0;

        // Table vectors, regrouped by remap config.
        for (int i = 0; i < 15; i++) begin
            if ({vecs[i].bad_en, vecs[i].idx, vecs[i].lsb} != cur_cfg)
                cfg_power(vecs[i].bad_en, vecs[i].idx, vecs[i].lsb);
            code = vecs[i].code;
            code_valid = 1'b1;
            sb.push_back(vecs[i].exp);
            step();
            code_valid = 1'b0;
            e = sb.pop_front();
            chk($sformatf("vec%0d", i), act_sel(), 32'(e));
        end

        // Back-to-back transfers with code_valid toggling, checked against the model.
        cfg_power(1'b1, 5'd7, 1'b1);
        last_exp = '0;
        for (int i = 0; i < 10; i++) begin
            code_valid = (i < 3) || (i % 2 == 1);
            code = 11'($urandom_range(0, 2047));
            if (code_valid) sb.push_back(model(code, 1'b1, 5'd7, 1'b1));
            step();
            if (code_valid) last_exp = sb.pop_front();
            chk($sformatf("b2b%0d", i), act_sel(), 32'(last_exp));
        end
        code_valid = 1'b0;

        // en drop with a simultaneous transfer, then en re-raised during DRAIN.
        code = 11'd677; code_valid = 1'b1; en = 1'b0;
        step();
        code_valid = 1'b0;
        chk("drain_ready", 32'(code_ready), 32'd0);
        chk("drain_sel", act_sel(), 32'd0);
        chk("drain_pdb0", 32'(pdb), 32'd1);
        en = 1'b1;
        step(); step(); step();
        chk("drain_pdb3", 32'(pdb), 32'd1);
        step();
        chk("drain_off", 32'(pdb), 32'd0);
        step();
        chk("drain_repwr", 32'(pdb), 32'd1);

        // Supply fault while ACTIVE with testbus enabled.
        cfg_power(1'b0, 5'd0, 1'b0);
        atb_sel = 2'b11;
        code = 11'd500; code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        chk("atb_active", 32'(atb_ena), 32'd3);
        supply_ok = 1'b0;
        step();
        chk("fault_pdb", 32'(pdb), 32'd0);
        chk("fault_atb", 32'(atb_ena), 32'd0);
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_sel", act_sel(), 32'd0);
        supply_ok = 1'b1;
        step(); step();
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_sticky_pdb", 32'(pdb), 32'd0);
        en = 1'b0;
        step();
        chk("fault_clear", 32'(fault), 32'd0);
        step();
        chk("fault_off_pdb", 32'(pdb), 32'd0);

        // Reset in the middle of ACTIVE.
        cfg_power(1'b0, 5'd0, 1'b0);
        atb_sel = 2'b10;
        code = 11'd677; code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        chk("prerst_sel", 32'(therm_sel), 32'h003FF);
        rst = 1'b1;
        step();
        chk("midrst_outs", {code_ready, pdb, atb_ena, active, fault, act_sel()[24:0]}, 32'd0);
        rst = 1'b0; en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/csu_dac_controller.md
# csu_dac_controller

Digital front end that drives the current source unit of the current-steering DAC. It sequences power-up and power-down (pdb), holds the analog testbus select (atb_ena), and accepts DAC codes over a valid/ready handshake. Each code is segmented into 16 thermometer cell selects plus one redundant cell, and 6 binary selects plus a redundant LSB. Optional remapping routes a faulty cell onto its redundant twin.

## Interface
Parameters:
- SETTLE_CYCLES, 64, cycles pdb is held high before codes are accepted (≥1)
- DRAIN_CYCLES, 4, cycles selects are held at zero with pdb high before power-down (≥1)

Ports:
- clk  in  1  block clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  request to power up and operate the current source unit
- supply_ok  in  1  from the supply/iref monitor; 1 = all references within bounds
- atb_sel  in  2  requested testbus selection
- bad_cell_en  in  1  enable thermometer cell remap
- bad_cell_idx  in  5  faulty thermometer cell index (0..15 valid)
- lsb_red_en  in  1  route binary bit 0 to the redundant LSB cell
- code  in  11  DAC code, 0..1024 valid
- code_valid  in  1  code is presented
- code_ready  out  1  controller accepts code this cycle
- pdb  out  1  power-down negate to the current source unit
- atb_ena  out  2  testbus select to the current source unit
- therm_sel  out  17  thermometer cell enables; bit 16 = redundant cell
- bin_sel  out  6  binary cell enables; bit 5 = MSB
- bin0_red_sel  out  1  redundant LSB cell enable
- active  out  1  controller is in ACTIVE
- fault  out  1  sticky supply fault
- sat  out  1  last accepted code was saturated

## Operation
- FSM states: OFF, PWRUP, ACTIVE, DRAIN, FAULT. Reset → OFF. Every output resets to 0.
- OFF: pdb=0, atb_ena=0, all selects 0. If en=1 and supply_ok=1, latch bad_cell_en, bad_cell_idx and lsb_red_en, then go to PWRUP. Remap config is static outside OFF.
- PWRUP: pdb=1, selects 0, counter runs for SETTLE_CYCLES. At terminal count → ACTIVE. en=0 → OFF directly.
- ACTIVE: pdb=1, code_ready=1, active=1. A transfer occurs when code_valid & code_ready. en=0 → DRAIN. A transfer in the same cycle as en=0 is still accepted, and its selects are then cleared in DRAIN.
- DRAIN: pdb=1, code_ready=0, selects 0 for DRAIN_CYCLES, then → OFF. en is ignored until OFF.
- FAULT: entered from PWRUP, ACTIVE or DRAIN when supply_ok=0. In that cycle: pdb=0, selects 0, atb_ena=0, fault=1. Leave to OFF only when en=0; fault clears on that exit.
- atb_ena = atb_sel, registered, in PWRUP/ACTIVE/DRAIN; 0 otherwise.
- Segmentation of an accepted code c:
  - Saturate first: c' = min(c, 1024); sat=1 iff c>1024.
  - t = c'[10:6] (0..16). Nominal therm bit k = 1 for k < t, k in 0..15.
  - bin_sel = c'[5:0].
- Remap: if the latched bad_cell_en=1 and idx≤15, nominal bit idx drives therm_sel[16] and therm_sel[idx]=0. If idx>15, remap is ignored and therm_sel[16]=0. Without remap, therm_sel[16]=0.
- LSB redundancy: if lsb_red_en=1, bin0_red_sel = c'[0] and bin_sel[0]=0. Otherwise bin0_red_sel=0.
- Selects and sat hold their value until the next transfer or until the state leaves ACTIVE.

## Timing
- Transfer at edge N → therm_sel/bin_sel/bin0_red_sel/sat valid after edge N+1 (1-cycle registered latency). Back-to-back transfers are supported, one per cycle.
- Power-up: en sampled high at edge 0 → pdb=1 after edge 1. code_ready=1 after edge 1+SETTLE_CYCLES.
- Power-down: en sampled low in ACTIVE at edge M → selects 0 and code_ready=0 after edge M+1 → pdb=0 after edge M+1+DRAIN_CYCLES.
- supply_ok low sampled at edge F → pdb=0 and fault=1 after edge F+1.
- rst mid-operation → all outputs 0 and state OFF after the same edge. Counters are cleared.

## Test plan
- Reset with en=1 → all outputs 0. With SETTLE_CYCLES=64: pdb=1 at cycle 1, code_ready=1 at cycle 65.
- ACTIVE, code=0x2A5 (677) → after 1 cycle: therm_sel=0x003FF, bin_sel=0x25, bin0_red_sel=0, sat=0. Then code=1024 → therm_sel=0x0FFFF, bin_sel=0. Then code=2000 → same selects, sat=1.
- bad_cell_en=1, idx=3, lsb_red_en=1, code=0x105 (261) → therm_sel=0x10007, bin_sel=0x04, bin0_red_sel=1. With idx=20 → therm_sel=0x0000F.
- 3 back-to-back transfers with code_valid toggling → each code reflected exactly one cycle after acceptance; non-transfer cycles hold the prior value.
- en drop in ACTIVE → code_ready=0 and selects 0 next cycle; pdb=0 after DRAIN_CYCLES=4 more cycles. An en re-raise during DRAIN is ignored until OFF.
- supply_ok=0 in ACTIVE with atb_sel=2'b11 → next cycle pdb=0, atb_ena=0, fault=1. fault stays set until en=0, then the FSM goes to OFF and fault=0.
